gpio_cmd_arbiter: RTL and testbench
===================================

// Module: gpio_cmd_arbiter
// PURPOSE
//  AHB-Lite single-master front end that shares the AHB GPIO peripheral between two command requesters.
//  Round-robin arbitration between the requesters. Each accepted command becomes one AHB transfer:
//  - write direction register (offset 0x04);
//  - write data register (offset 0x00);
//  - read input register (offset 0x00).
//  Returns a response to the requester that issued the command. Sits between local controllers and the GPIO slave port.
// PARAMETERS
//  GPIO_BASE   32'h5000_0000  GPIO base address; HADDR = GPIO_BASE | offset
//  TIMEOUT     16             max consecutive HREADY-low cycles in one phase before abort (>=1)
// PORTS
//  HCLK          in   1   clock, rising edge
//  HRESETn       in   1   asynchronous, active-low reset
//  reqN_valid    in   1   N=0,1: command present; hold until reqN_ready
//  reqN_write    in   1   1=write, 0=read
//  reqN_dir      in   1   1=direction reg (0x04), 0=data reg (0x00); reads ignore it (always 0x00)
//  reqN_wdata    in   16  write payload
//  reqN_ready    out  1   command accepted this cycle (valid & ready)
//  rspN_valid    out  1   one-cycle response pulse
//  rspN_rdata    out  16  read data (HRDATA[15:0]); 0 for writes/errors
//  rspN_err      out  1   transfer aborted by timeout
//  HSEL          out  1   GPIO slave select
//  HADDR         out  32  AHB address
//  HTRANS        out  2   2'b10 NONSEQ in address phase, else 2'b00
//  HWRITE        out  1   transfer direction
//  HSIZE         out  3   always 3'b010
//  HWDATA        out  32  {16'h0, wdata} during data phase of writes, else 0
//  HREADY        in   1   from slave HREADYOUT
//  HRDATA        in   32  slave read data
//  busy          out  1   FSM not IDLE
// BEHAVIOUR
//  Reset values (asynchronous):
//  - HSEL=0, HTRANS=00, HWRITE=0, HADDR=GPIO_BASE, HWDATA=0.
//  - all ready/rsp outputs = 0; busy=0.
//  - state=IDLE; rr pointer last=1 (req0 wins first).
//  FSM IDLE -> ADDR -> DATA -> IDLE; no pipelining, one transfer in flight.
//  IDLE:
//  - reqN_ready is combinational: IDLE & reqN_valid & granted.
//  - Grant rules:
//    - only one valid -> that one is granted;
//    - both valid -> the requester other than the last granted wins.
//  - On accept: latch cmd and requester id, update last, go to ADDR.
//  ADDR:
//  - HSEL=1, HTRANS=10, HADDR/HWRITE from latched cmd.
//  - HREADY=1 at edge -> DATA.
//  - HREADY=0 -> hold all signals stable.
//  DATA:
//  - HTRANS=00, HSEL=0; HWDATA driven for writes.
//  - HREADY=1 at edge -> capture HRDATA[15:0] (reads only); pulse rsp of owner next cycle; go to IDLE.
//  Latency: accept at edge E0, ADDR cycle E0-E1, DATA cycle E1-E2, rsp_valid high E2-E3 (2 cycles from accept).
//  - With zero wait states, the next accept is no earlier than E3.
//  - Stall cycles add 1:1 latency.
//  Timeout: separate counter per phase, cleared on phase entry.
//  - Reaching TIMEOUT with HREADY low -> rsp_valid=1, rsp_err=1, rdata=0; HTRANS=00; go to IDLE.
//  Requester dropping valid while not ready: no effect. rsp of the non-owner stays 0.
//  Reset mid-transfer: immediate return to reset values; no response issued; the command is lost.
// TESTING
//  1. Reset, req0 write dir=1, wdata=0x0001:
//     - ADDR cycle HADDR=0x5000_0004, HTRANS=10, HWRITE=1;
//     - DATA cycle HWDATA=0x0000_0001;
//     - rsp0_valid 2 cycles after accept, err=0.
//  2. After test 1, req0 write data 0xA5A5 -> GPIOOUT=0xA5A5; then req0 read -> rsp0_rdata=0xA5A5.
//  3. req0 and req1 both valid continuously -> grants alternate 0,1,0,1; rsp pulses go to the matching requester only.
//  4. HREADY low for 3 cycles in DATA -> HWDATA/state held; rsp delayed exactly 3 cycles; data correct.
//  5. HREADY low for TIMEOUT=16 cycles in ADDR -> rsp_err=1, rdata=0, busy=0 next cycle; the next command completes normally.
//  6. HRESETn low during DATA -> all outputs at reset values at once, no rsp pulse; after release, simultaneous requests grant req0 first.

Source files
------------

// File: rtl/gpio_cmd_arbiter.sv
// Round-robin front end sharing the AHB-Lite GPIO slave between two command requesters.
// Each accepted command becomes one non-pipelined AHB transfer; the response returns to its issuer.
module gpio_cmd_arbiter #(
   parameter logic [31:0] GPIO_BASE = 32'h5000_0000,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req0_valid,
   input  logic        req0_write,
   input  logic        req0_dir,
   input  logic [15:0] req0_wdata,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic        req1_write,
   input  logic        req1_dir,
   input  logic [15:0] req1_wdata,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic [15:0] rsp0_rdata,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   output logic [15:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic        HSEL,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic        busy
);

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 32;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                write_q, write_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                hsel_q, hsel_d;
   logic [1:0]          htrans_q, htrans_d;
   logic [AW-1:0]       haddr_q, haddr_d;
   logic                hwrite_q, hwrite_d;
   logic [AW-1:0]       hwdata_q, hwdata_d;
   logic                busy_q, busy_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [1:0]          rsp_err_q, rsp_err_d;
   logic [1:0][DW-1:0]  rsp_rdata_q, rsp_rdata_d;

   logic                gnt0_c, gnt1_c;
   logic                sel_write_c, sel_dir_c;
   logic [DW-1:0]       sel_wdata_c;
   logic                stall_out_c;
   logic                unused_hrdata;

   // The requester that did not win last time has priority when both are pending.
   assign gnt0_c      = req0_valid & (~req1_valid | last_q);
   assign gnt1_c      = req1_valid & (~req0_valid | ~last_q);
   assign req0_ready  = (state_q == ST_IDLE) & gnt0_c;
   assign req1_ready  = (state_q == ST_IDLE) & gnt1_c;
   assign sel_write_c = gnt1_c ? req1_write : req0_write;
   assign sel_dir_c   = gnt1_c ? req1_dir   : req0_dir;
   assign sel_wdata_c = gnt1_c ? req1_wdata : req0_wdata;
   assign stall_out_c = ~HREADY & (cnt_q == CW'(TIMEOUT - 1));
   assign unused_hrdata = ^HRDATA[AW-1:DW];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      hsel_d      = hsel_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hwdata_d    = hwdata_q;
      rsp_valid_d = 2'b00;
      rsp_err_d   = 2'b00;
      rsp_rdata_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt0_c || gnt1_c) begin
               owner_d  = gnt1_c;
               last_d   = gnt1_c;
               write_d  = sel_write_c;
               wdata_d  = sel_wdata_c;
               haddr_d  = GPIO_BASE | {29'h0, sel_write_c & sel_dir_c, 2'b00};
               hsel_d   = 1'b1;
               htrans_d = 2'b10;
               hwrite_d = sel_write_c;
               cnt_d    = '0;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               hsel_d   = 1'b0;
               htrans_d = 2'b00;
               hwdata_d = write_q ? {16'h0, wdata_q} : '0;
               cnt_d    = '0;
               state_d  = ST_DATA;
            end else if (stall_out_c) begin
               hsel_d               = 1'b0;
               htrans_d             = 2'b00;
               hwrite_d             = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d[owner_q]   = 1'b1;
               state_d              = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (HREADY || stall_out_c) begin
               hwdata_d             = '0;
               hwrite_d             = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d[owner_q]   = ~HREADY;
               if (HREADY && !write_q) rsp_rdata_d[owner_q] = HRDATA[DW-1:0];
               state_d              = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         hsel_q      <= 1'b0;
         htrans_q    <= 2'b00;
         haddr_q     <= GPIO_BASE;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 2'b00;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         hsel_q      <= hsel_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign HSEL       = hsel_q;
   assign HADDR      = haddr_q;
   assign HTRANS     = htrans_q;
   assign HWRITE     = hwrite_q;
   assign HSIZE      = 3'b010;
   assign HWDATA     = hwdata_q;
   assign busy       = busy_q;
   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp0_err   = rsp_err_q[0];
   assign rsp1_err   = rsp_err_q[1];
   assign rsp0_rdata = rsp_rdata_q[0];
   assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_gpio_cmd_arbiter.sv
// Testbench for gpio_cmd_arbiter: GPIO slave with output-to-input loopback, transaction-level
// expectations for round-robin grant, bus phases, response routing, stalls, timeout and reset.
module tb_gpio_cmd_arbiter;

   localparam logic [31:0] BASE = 32'h5000_0000;
   localparam int          TO   = 16;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b1;
   always #5 HCLK = ~HCLK;

   logic [1:0]  req_valid, req_write, req_dir, req_ready, rsp_valid, rsp_err;
   logic [15:0] req_wdata [2];
   logic [15:0] rsp_rdata [2];
   logic        HSEL, HWRITE, HREADY, busy;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [31:0] HADDR, HWDATA, HRDATA;

   int checks = 0;
   int errors = 0;

   // Reference model: GPIO register contents and last granted requester
   logic [15:0] m_out, m_dir;
   int          m_last;

   // GPIO slave: data register loops back as the input register
   logic        dph_v, dph_w;
   logic [31:0] dph_a;
   logic [15:0] s_out, s_dir;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dph_v <= 1'b0; dph_w <= 1'b0; dph_a <= '0; s_out <= '0; s_dir <= '0;
      end else if (HREADY) begin
         if (dph_v && dph_w) begin
            if (dph_a[2]) s_dir <= HWDATA[15:0];
            else          s_out <= HWDATA[15:0];
         end
         dph_v <= HSEL && HTRANS[1];
         dph_a <= HADDR;
         dph_w <= HWRITE;
      end
   end
   assign HRDATA = (dph_v && !dph_w) ? {16'hBEEF, s_out} : 32'h0;

   gpio_cmd_arbiter #(.GPIO_BASE(BASE), .TIMEOUT(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req0_valid(req_valid[0]), .req0_write(req_write[0]), .req0_dir(req_dir[0]),
      .req0_wdata(req_wdata[0]), .req0_ready(req_ready[0]),
      .req1_valid(req_valid[1]), .req1_write(req_write[1]), .req1_dir(req_dir[1]),
      .req1_wdata(req_wdata[1]), .req1_ready(req_ready[1]),
      .rsp0_valid(rsp_valid[0]), .rsp0_rdata(rsp_rdata[0]), .rsp0_err(rsp_err[0]),
      .rsp1_valid(rsp_valid[1]), .rsp1_rdata(rsp_rdata[1]), .rsp1_err(rsp_err[1]),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .busy(busy)
   );

   // Runs one transfer whose accept edge is the next rising edge; ends on the response cycle.
   task automatic run_xfer(input int id, input logic wr, input logic dir, input logic [15:0] wd,
                           input int astall, input int dstall, input bit keep, input string tag);
      logic [31:0] ea;
      logic [15:0] er;
      logic [36:0] exp_a, got_a;
      logic [36:0] exp_d, got_d;
      ea = BASE | ((wr && dir) ? 32'h4 : 32'h0);
      er = wr ? 16'h0 : m_out;
      HREADY = 1'b1;
      @(negedge HCLK);
      req_valid[id] = keep;
      req_write[id] = 1'($urandom);
      req_dir[id]   = 1'($urandom);
      req_wdata[id] = 16'($urandom);
      exp_a = {1'b1, 2'b10, wr, 1'b1, ea};
      got_a = {HSEL, HTRANS, HWRITE, busy, HADDR};
      checks++;
      if (got_a !== exp_a) begin
         errors++; $display("FAIL %s addr_phase got %h exp %h", tag, got_a, exp_a);
      end
      for (int k = 1; k <= astall; k++) begin
         HREADY = 1'b0;
         @(negedge HCLK);
         if (k == TO) begin
            checks++;
            if ({rsp_valid[id], rsp_err[id], rsp_rdata[id], rsp_valid[1-id], HSEL, HTRANS, busy}
                !== {1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
               errors++;
               $display("FAIL %s timeout_rsp got v=%b e=%b d=%h ov=%b sel=%b tr=%b busy=%b exp 1 1 0000 0 0 00 0",
                        tag, rsp_valid[id], rsp_err[id], rsp_rdata[id], rsp_valid[1-id], HSEL, HTRANS, busy);
            end
            HREADY = 1'b1;
            @(negedge HCLK);
            checks++;
            if (rsp_valid !== 2'b00) begin
               errors++; $display("FAIL %s timeout_pulse got %b exp 00", tag, rsp_valid);
            end
            return;
         end
         got_a = {HSEL, HTRANS, HWRITE, busy, HADDR};
         checks++;
         if (got_a !== exp_a || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL %s addr_hold got %h rsp %b exp %h rsp 00", tag, got_a, rsp_valid, exp_a);
         end
      end
      HREADY = 1'b1;
      @(negedge HCLK);
      exp_d = {1'b0, 2'b00, 1'b1, 1'b0, (wr ? {16'h0, wd} : 32'h0)};
      got_d = {HSEL, HTRANS, busy, |rsp_valid, HWDATA};
      checks++;
      if (got_d !== exp_d) begin
         errors++; $display("FAIL %s data_phase got %h exp %h", tag, got_d, exp_d);
      end
      for (int k = 1; k <= dstall; k++) begin
         HREADY = 1'b0;
         @(negedge HCLK);
         got_d = {HSEL, HTRANS, busy, |rsp_valid, HWDATA};
         checks++;
         if (got_d !== exp_d) begin
            errors++; $display("FAIL %s data_hold got %h exp %h", tag, got_d, exp_d);
         end
      end
      HREADY = 1'b1;
      @(negedge HCLK);
      if (wr) begin
         if (dir) m_dir = wd;
         else     m_out = wd;
      end
      checks++;
      if ({rsp_valid[id], rsp_err[id], rsp_rdata[id]} !== {1'b1, 1'b0, er}) begin
         errors++;
         $display("FAIL %s rsp got v=%b e=%b d=%h exp v=1 e=0 d=%h", tag, rsp_valid[id], rsp_err[id], rsp_rdata[id], er);
      end
      checks++;
      if ({rsp_valid[1-id], busy} !== 2'b00) begin
         errors++; $display("FAIL %s other_rsp_busy got %b%b exp 00", tag, rsp_valid[1-id], busy);
      end
   endtask

   task automatic issue(input int id, input logic wr, input logic dir, input logic [15:0] wd,
                        input int astall, input int dstall, input string tag);
      int n = 0;
      req_write[id] = wr; req_dir[id] = dir; req_wdata[id] = wd; req_valid[id] = 1'b1;
      #1;
      while (req_ready[id] !== 1'b1 && n < 20) begin
         @(negedge HCLK); #1; n++;
      end
      checks++;
      if (req_ready !== 2'(1 << id)) begin
         errors++; $display("FAIL %s ready got %b exp %b", tag, req_ready, 2'(1 << id));
      end
      if (req_ready[id] !== 1'b1) begin
         req_valid[id] = 1'b0;
         return;
      end
      m_last = id;
      run_xfer(id, wr, dir, wd, astall, dstall, 1'b0, tag);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      checks++;
      if ({HSEL, HTRANS, HWRITE, HADDR, HWDATA, HSIZE, busy, rsp_valid, rsp_err, req_ready, rsp_rdata[0], rsp_rdata[1]}
          !== {1'b0, 2'b00, 1'b0, BASE, 32'h0, 3'b010, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0}) begin
         errors++;
         $display("FAIL reset got sel=%b tr=%b wr=%b a=%h wd=%h sz=%b busy=%b rv=%b re=%b rdy=%b", HSEL, HTRANS,
                  HWRITE, HADDR, HWDATA, HSIZE, busy, rsp_valid, rsp_err, req_ready);
      end
      HRESETn = 1'b1;
      m_out = '0; m_dir = '0; m_last = 1;
   endtask

   task automatic test_basic();
      issue(0, 1'b1, 1'b1, 16'h0001, 0, 0, "dir_write");
      checks++;
      if (s_dir !== m_dir) begin
         errors++; $display("FAIL gpio_dir got %h exp %h", s_dir, m_dir);
      end
      issue(0, 1'b1, 1'b0, 16'hA5A5, 0, 0, "data_write");
      checks++;
      if (s_out !== 16'hA5A5) begin
         errors++; $display("FAIL gpio_out got %h exp a5a5", s_out);
      end
      issue(0, 1'b0, 1'b1, 16'h0000, 0, 0, "read_back");
   endtask

   task automatic test_back_to_back();
      int n;
      int exp;
      req_valid = 2'b11;
      for (int r = 0; r < 2; r++) begin
         req_write[r] = 1'($urandom); req_dir[r] = 1'($urandom); req_wdata[r] = 16'($urandom);
      end
      for (int i = 0; i < 6; i++) begin
         exp = 1 - m_last;
         n = 0;
         #1;
         while (req_ready === 2'b00 && n < 20) begin
            @(negedge HCLK); #1; n++;
         end
         checks++;
         if (req_ready !== 2'(1 << exp)) begin
            errors++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, 2'(1 << exp));
         end
         if (req_ready === 2'b00) break;
         m_last = exp;
         run_xfer(exp, req_write[exp], req_dir[exp], req_wdata[exp], 0, 0, 1'b1, "rr");
      end
      req_valid = 2'b00;
   endtask

   task automatic test_data_stall();
      issue(1, 1'b1, 1'b0, 16'h5AC3, 0, 3, "data_stall_wr");
      issue(1, 1'b0, 1'b0, 16'h0000, 0, 3, "data_stall_rd");
   endtask

   task automatic test_timeout();
      issue(1, 1'b0, 1'b0, 16'h0000, TO, 0, "addr_timeout");
      issue(1, 1'b1, 1'b0, 16'h3C3C, 0, 0, "post_to_wr");
      issue(0, 1'b0, 1'b0, 16'h0000, 0, 0, "post_to_rd");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         issue(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      req_write[0] = 1'b1; req_dir[0] = 1'b0; req_wdata[0] = 16'h1234; req_valid[0] = 1'b1;
      #1;
      while (req_ready[0] !== 1'b1 && n < 20) begin
         @(negedge HCLK); #1; n++;
      end
      @(negedge HCLK);
      req_valid[0] = 1'b0;
      @(negedge HCLK);
      HREADY = 1'b0;
      HRESETn = 1'b0;
      #1;
      checks++;
      if ({HSEL, HTRANS, HWRITE, HADDR, HWDATA, busy, rsp_valid, rsp_err}
          !== {1'b0, 2'b00, 1'b0, BASE, 32'h0, 1'b0, 2'b00, 2'b00}) begin
         errors++;
         $display("FAIL mid_reset got sel=%b tr=%b wr=%b a=%h wd=%h busy=%b rv=%b re=%b", HSEL, HTRANS, HWRITE,
                  HADDR, HWDATA, busy, rsp_valid, rsp_err);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      HREADY = 1'b1;
      m_out = '0; m_dir = '0; m_last = 1;
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++; $display("FAIL mid_reset_rsp got %b exp 00", rsp_valid);
      end
      req_write = 2'b00; req_dir = 2'b00; req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL post_reset_grant got %b exp 01", req_ready);
      end
      m_last = 0;
      run_xfer(0, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, "post_reset_rd");
      req_valid = 2'b00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0; req_write = '0; req_dir = '0;
      req_wdata[0] = '0; req_wdata[1] = '0;
      HREADY = 1'b1;
      m_out = '0; m_dir = '0; m_last = 1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_data_stall();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
